fixed_pt_dot_accumulator: RTL

Sequential stage directly downstream of the fixed-point multiplier in the vector multiplier datapath. Consumes a stream of signed fixed-point element products, one per handshake, and sums `VECTOR_LENGTH` of them into a dot-product result. The sum uses a widened internal accumulator. The block presents the result saturated back to `OPERAND_WIDTH`, with a saturation flag, behind a valid/ready output handshake.

---
 rtl/fixed_pt_dot_accumulator.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/fixed_pt_dot_accumulator.sv
// fixed_pt_dot_accumulator
// Sums VECTOR_LENGTH signed fixed-point products into a widened accumulator and
// presents the result, clamped back to OPERAND_WIDTH, behind a valid/ready
// output handshake. Only the final sum is clamped; partial sums ride in the
// guard bits and can never wrap.

module fixed_pt_dot_accumulator #(
  parameter int OPERAND_WIDTH = 24,
  parameter int DECIMAL_PLACE = 12,
  parameter int VECTOR_LENGTH = 3,
  parameter int GUARD_BITS    = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     abort_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [OPERAND_WIDTH-1:0] in_product_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [OPERAND_WIDTH-1:0] out_sum_o,
  output logic                     out_saturated_o
);

  // Accumulator carries GUARD_BITS extra MSBs so a full vector cannot wrap.
  localparam int ACC_W = OPERAND_WIDTH + GUARD_BITS;

  // Element counter is at least one bit wide so VECTOR_LENGTH == 1 still works.
  localparam int CNT_W = (VECTOR_LENGTH > 1) ? $clog2(VECTOR_LENGTH) : 1;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VECTOR_LENGTH - 1);

  // Clamp values: largest positive and most negative OPERAND_WIDTH numbers.
  localparam logic [OPERAND_WIDTH-1:0] SAT_POS = {1'b0, {(OPERAND_WIDTH-1){1'b1}}};
  localparam logic [OPERAND_WIDTH-1:0] SAT_NEG = {1'b1, {(OPERAND_WIDTH-1){1'b0}}};

  // Elaboration-time sanity checks on the parameter set. The fractional bit
  // count does not affect the arithmetic (products already share one format),
  // so it only has to describe a sensible format.
  if (VECTOR_LENGTH < 1) begin : g_bad_len
    $error("VECTOR_LENGTH must be at least 1");
  end
  if (GUARD_BITS < 1 || (1 << GUARD_BITS) < VECTOR_LENGTH) begin : g_bad_guard
    $error("GUARD_BITS too small to hold VECTOR_LENGTH products without wrap");
  end
  if (DECIMAL_PLACE < 0 || DECIMAL_PLACE >= OPERAND_WIDTH) begin : g_bad_frac
    $error("DECIMAL_PLACE must lie inside OPERAND_WIDTH");
  end

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } state_e;

  state_e                     state_q, state_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic [OPERAND_WIDTH-1:0]   out_sum_q, out_sum_d;
  logic                       out_sat_q, out_sat_d;

  logic signed [OPERAND_WIDTH-1:0] product_s;
  logic signed [ACC_W-1:0]         product_ext;
  logic signed [ACC_W-1:0]         acc_sum;
  logic [GUARD_BITS:0]             acc_top;
  logic                            sum_fits;
  logic [OPERAND_WIDTH-1:0]        sat_sum;
  logic                            sat_flag;

  // Handshake outputs decode straight from the registered state, so there is
  // no combinational path from out_ready_i to in_ready_o.
  assign in_ready_o      = (state_q == ST_ACCUM);
  assign out_valid_o     = (state_q == ST_DONE);
  assign out_sum_o       = out_sum_q;
  assign out_saturated_o = out_sat_q;

  // Sign-extend the incoming product and form the candidate running sum.
  always_comb begin
    product_s   = in_product_i;
    product_ext = ACC_W'(product_s);
    acc_sum     = acc_q + product_ext;
  end

  // Clamp the candidate sum: it fits only if every bit above the result's
  // sign bit matches that sign bit.
  always_comb begin
    acc_top  = acc_sum[ACC_W-1:OPERAND_WIDTH-1];
    sum_fits = (&acc_top) | ~(|acc_top);
    sat_sum  = acc_sum[OPERAND_WIDTH-1:0];
    sat_flag = 1'b0;
    if (!sum_fits) begin
      sat_flag = 1'b1;
      sat_sum  = acc_sum[ACC_W-1] ? SAT_NEG : SAT_POS;
    end
  end

  // Next-state logic: abort wins over any same-cycle transfer, otherwise
  // accumulate in ACCUM and hold the result in DONE until it is taken.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    count_d   = count_q;
    out_sum_d = out_sum_q;
    out_sat_d = out_sat_q;

    if (abort_i) begin
      state_d = ST_ACCUM;
      acc_d   = '0;
      count_d = '0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (in_valid_i) begin
            acc_d = acc_sum;
            if (count_q == LAST_IDX) begin
              count_d   = '0;
              state_d   = ST_DONE;
              out_sum_d = sat_sum;
              out_sat_d = sat_flag;
            end else begin
              count_d = count_q + CNT_W'(1);
            end
          end
        end
        ST_DONE: begin
          if (out_ready_i) begin
            acc_d   = '0;
            state_d = ST_ACCUM;
          end
        end
        default: begin
          state_d = ST_ACCUM;
          acc_d   = '0;
          count_d = '0;
        end
      endcase
    end
  end

  // State registers; reset discards any partial or pending result.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_ACCUM;
      acc_q     <= '0;
      count_q   <= '0;
      out_sum_q <= '0;
      out_sat_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      out_sum_q <= out_sum_d;
      out_sat_q <= out_sat_d;
    end
  end

endmodule
